// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front end for WIDTH asynchronous, active-high board inputs (buttons and
// switches) in the cpu_clk domain. Each channel has:
//   - a 2-flop synchronizer,
//   - a debouncer that only changes state after PULSE_CNT_MAX consecutive
//     agreeing samples, with the same filtering for press and release,
//   - single-cycle press/release event pulses,
//   - an optional hold-to-repeat mode, enabled per channel by REPEAT_EN.
// One sample tick is shared by all channels. It fires once every
// SAMPLE_CNT_MAX clocks.
//
// Ports
//   clk      : cpu_clk. All logic runs on the rising edge.
//   rst      : synchronous active-high reset.
//   in       : raw asynchronous inputs, active-high.
//   level    : debounced state. It is 1 while the channel is pressed or
//              repeating.
//   pressed  : 1-cycle pulse on each debounced rising edge.
//   released : 1-cycle pulse on each debounced falling edge.
//   rpt      : 1-cycle pulse for each auto-repeat event. This is the
//              "repeat" output; it is named rpt because repeat is a reserved
//              word in SystemVerilog.
//
// All outputs are registered. They change in the cycle after the sample tick
// that decides them.
// -----------------------------------------------------------------------------
module input_conditioner #(
    parameter int unsigned      WIDTH          = 4,
    parameter int unsigned      SAMPLE_CNT_MAX = 25_000,
    parameter int unsigned      PULSE_CNT_MAX  = 200,
    parameter int unsigned      HOLD_CNT_MAX   = 1000,
    parameter int unsigned      REPEAT_CNT_MAX = 200,
    parameter logic [WIDTH-1:0] REPEAT_EN      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] rpt
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_CNT_MAX);
    localparam int unsigned ON_W   = $clog2(PULSE_CNT_MAX + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CNT_MAX + 1);
    localparam int unsigned RPT_W  = $clog2(REPEAT_CNT_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1'b1);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [ON_W-1:0]   ON_TOP    = ON_W'(PULSE_CNT_MAX);
    localparam logic [ON_W-1:0]   ON_ONE    = ON_W'(1'b1);
    localparam logic [ON_W-1:0]   ON_ZERO   = {ON_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_CNT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [RPT_W-1:0]  RPT_TOP   = RPT_W'(REPEAT_CNT_MAX);
    localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1'b1);
    localparam logic [RPT_W-1:0]  RPT_ZERO  = {RPT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    logic [WIDTH-1:0]  sync1_r;
    logic [WIDTH-1:0]  sync2_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;

    // Two-stage synchronizer. The raw input goes straight into the first flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    // Shared sample-tick divider. It counts 0..SAMPLE_CNT_MAX-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= TICK_ZERO;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= TICK_ZERO;
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t            state_r, state_s;
        logic [ON_W-1:0]   on_r, on_s, on_inc_s;
        logic [ON_W-1:0]   off_r, off_s, off_inc_s;
        logic [HOLD_W-1:0] hold_r, hold_s, hold_inc_s;
        logic [RPT_W-1:0]  rpt_cnt_r, rpt_cnt_s, rpt_inc_s;
        logic              pressed_s, released_s, rpt_s;
        logic              level_r, pressed_r, released_r, rpt_r;

        // Next-state and event decode. Nothing moves except on a sample tick.
        always_comb begin
            state_s    = state_r;
            on_s       = on_r;
            off_s      = off_r;
            hold_s     = hold_r;
            rpt_cnt_s  = rpt_cnt_r;
            pressed_s  = 1'b0;
            released_s = 1'b0;
            rpt_s      = 1'b0;
            // Saturating increments. The counters never wrap back into range.
            on_inc_s   = (on_r == ON_TOP) ? on_r : on_r + ON_ONE;
            off_inc_s  = (off_r == ON_TOP) ? off_r : off_r + ON_ONE;
            hold_inc_s = (hold_r == HOLD_TOP) ? hold_r : hold_r + HOLD_ONE;
            rpt_inc_s  = (rpt_cnt_r == RPT_TOP) ? rpt_cnt_r : rpt_cnt_r + RPT_ONE;

            if (tick_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (sync2_r[i]) begin
                            if (on_inc_s == ON_TOP) begin
                                state_s   = ST_PRESSED;
                                pressed_s = 1'b1;
                                on_s      = ON_ZERO;
                                off_s     = ON_ZERO;
                                hold_s    = HOLD_ZERO;
                                rpt_cnt_s = RPT_ZERO;
                            end else begin
                                on_s = on_inc_s;
                            end
                        end else begin
                            on_s = ON_ZERO;
                        end
                    end
                    ST_PRESSED, ST_REPEAT: begin
                        // A low sample is checked first. This gives release
                        // priority over repeat.
                        if (!sync2_r[i]) begin
                            if (off_inc_s == ON_TOP) begin
                                state_s    = ST_IDLE;
                                released_s = 1'b1;
                                on_s       = ON_ZERO;
                                off_s      = ON_ZERO;
                                hold_s     = HOLD_ZERO;
                                rpt_cnt_s  = RPT_ZERO;
                            end else begin
                                off_s = off_inc_s;
                            end
                        end else begin
                            off_s = ON_ZERO;
                            if (state_r == ST_PRESSED) begin
                                if ((REPEAT_EN[i] == 1'b1) && (hold_inc_s == HOLD_TOP)) begin
                                    state_s   = ST_REPEAT;
                                    rpt_s     = 1'b1;
                                    hold_s    = HOLD_ZERO;
                                    rpt_cnt_s = RPT_ZERO;
                                end else begin
                                    // With repeat disabled, hold_cnt simply
                                    // sits at its saturated value.
                                    hold_s = hold_inc_s;
                                end
                            end else begin
                                if (rpt_inc_s == RPT_TOP) begin
                                    rpt_s     = 1'b1;
                                    rpt_cnt_s = RPT_ZERO;
                                end else begin
                                    rpt_cnt_s = rpt_inc_s;
                                end
                            end
                        end
                    end
                    default: begin
                        state_s   = ST_IDLE;
                        on_s      = ON_ZERO;
                        off_s     = ON_ZERO;
                        hold_s    = HOLD_ZERO;
                        rpt_cnt_s = RPT_ZERO;
                    end
                endcase
            end else begin
                state_s = state_r;
            end
        end

        // State, counters and registered outputs. A reset aborts without a
        // release event.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r    <= ST_IDLE;
                on_r       <= ON_ZERO;
                off_r      <= ON_ZERO;
                hold_r     <= HOLD_ZERO;
                rpt_cnt_r  <= RPT_ZERO;
                level_r    <= 1'b0;
                pressed_r  <= 1'b0;
                released_r <= 1'b0;
                rpt_r      <= 1'b0;
            end else begin
                state_r    <= state_s;
                on_r       <= on_s;
                off_r      <= off_s;
                hold_r     <= hold_s;
                rpt_cnt_r  <= rpt_cnt_s;
                level_r    <= (state_s != ST_IDLE);
                pressed_r  <= pressed_s;
                released_r <= released_s;
                rpt_r      <= rpt_s;
            end
        end

        assign level[i]    = level_r;
        assign pressed[i]  = pressed_r;
        assign released[i] = released_r;
        assign rpt[i]      = rpt_r;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed, table-driven bench for input_conditioner. It uses
// SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, HOLD_CNT_MAX=5, REPEAT_CNT_MAX=2 and
// REPEAT_EN=4'b0001.
//
// Timing convention: "cycle n" is rising edge n after reset is released.
// Cycle 0 is the first edge with rst low. Inputs for cycle n are driven on
// the falling edge before edge n. The outputs seen at that same falling edge
// are the outputs for cycle n, i.e. the values edge n samples.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic [3:0] level;
    logic [3:0] pressed;
    logic [3:0] released;
    logic [3:0] rpt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic       r;
        int         n;
        logic [3:0] vin;
        logic [3:0] el;
        logic [3:0] ep;
        logic [3:0] erl;
        logic [3:0] ert;
    } seg_t;

    seg_t segs[14];

    input_conditioner #(
        .WIDTH         (4),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3),
        .HOLD_CNT_MAX  (5),
        .REPEAT_CNT_MAX(2),
        .REPEAT_EN     (4'b0001)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .level   (level),
        .pressed (pressed),
        .released(released),
        .rpt     (rpt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle and check that cycle's outputs (and tick when not in
    // reset), then advance to the next falling edge.
    task automatic run_cycle(input logic r, input logic [3:0] vin, input logic [3:0] el,
                             input logic [3:0] ep, input logic [3:0] erl, input logic [3:0] ert);
        logic exp_tick;
        rst = r;
        in  = vin;
        chk("level", level, el);
        chk("pressed", pressed, ep);
        chk("released", released, erl);
        chk("repeat", rpt, ert);
        if (!r) begin
            exp_tick = ((cyc % 4) == 3);
            chk("tick", {3'b000, dut.tick_s}, {3'b000, exp_tick});
        end
        @(negedge clk);
        if (r) cyc = 0;
        else   cyc++;
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        in  = 4'b0000;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        segs[0]  = '{1'b0, 100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        segs[1]  = '{1'b1,   2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        segs[2]  = '{1'b0,  12, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        segs[3]  = '{1'b0,   1, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        segs[4]  = '{1'b0,   7, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        segs[5]  = '{1'b0,  12, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        segs[6]  = '{1'b0,   1, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0001};
        segs[7]  = '{1'b0,   7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        segs[8]  = '{1'b0,   1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        segs[9]  = '{1'b0,   7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        segs[10] = '{1'b0,   1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        segs[11] = '{1'b0,   7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        segs[12] = '{1'b0,   1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        segs[13] = '{1'b0,   3, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

        // Initial reset. The table then starts at cycle 0.
        rst = 1'b1;
        in  = 4'b0000;
        repeat (3) @(negedge clk);
        cyc = 0;

        // Table phase:
        //   - 100 idle cycles;
        //   - re-reset;
        //   - ch1 press then release;
        //   - ch0 hold-to-repeat.
        for (int s = 0; s < 14; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                run_cycle(segs[s].r, segs[s].vin, segs[s].el, segs[s].ep, segs[s].erl, segs[s].ert);
            end
        end

        // ch0 and ch3 rise together. rst is pulsed during REPEAT, then a
        // fresh press follows while the inputs stay high.
        reset_dut(2);
        for (int c = 0; c < 34; c++) begin
            run_cycle(1'b0, 4'b1001, (c >= 12) ? 4'b1001 : 4'b0000,
                      (c == 12) ? 4'b1001 : 4'b0000, 4'b0000,
                      (c == 32) ? 4'b0001 : 4'b0000);
        end
        run_cycle(1'b1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        for (int c = 0; c < 14; c++) begin
            run_cycle(1'b0, 4'b1001, (c >= 12) ? 4'b1001 : 4'b0000,
                      (c == 12) ? 4'b1001 : 4'b0000, 4'b0000, 4'b0000);
        end

        // Glitch rejection on ch2. The first phase must not produce a press;
        // after a real press, the second phase must not produce a release.
        reset_dut(2);
        for (int c = 0; c < 80; c++) begin
            run_cycle(1'b0, ((c % 10) < 6) ? 4'b0100 : 4'b0000,
                      4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        for (int c = 80; c < 96; c++) begin
            run_cycle(1'b0, 4'b0100, (c >= 92) ? 4'b0100 : 4'b0000,
                      (c == 92) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000);
        end
        for (int c = 96; c < 176; c++) begin
            run_cycle(1'b0, (((c - 96) % 10) < 6) ? 4'b0000 : 4'b0100,
                      4'b0100, 4'b0000, 4'b0000, 4'b0000);
        end
        for (int c = 176; c < 196; c++) begin
            run_cycle(1'b0, 4'b0000, (c < 188) ? 4'b0100 : 4'b0000, 4'b0000,
                      (c == 188) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
